uart_rx: RTL

UART receiver, the receive-side companion of the team's uart_tx. It deserializes frames of 1 start bit (0), WIDTH data bits and 1 stop bit (1), with an idle-high line and a bit period of DIVISOR clk cycles. It presents each received word on a parallel bus with a one-cycle valid strobe and flags framing errors. Parameters match uart_tx, so an identically parameterized pair loops back directly.

---
 rtl/uart_rx.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 1 start bit, WIDTH data bits and 1 stop bit, DIVISOR clk cycles per bit.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote at every sample point.
module uart_rx #(
    parameter int WIDTH         = 8,
    parameter int DIVISOR       = 100,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_busy,
    output logic             o_frame_err
);
    localparam int CW = $clog2(DIVISOR);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             sample, rx_bit, dv_n, ferr_n;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;
    logic [2:0] vote;

    always_ff @(posedge clk) begin
        if (i_reset) rx_hist <= 2'b11;
        else         rx_hist <= {rx_hist[0], rx_s};
    end

    // vote holds rx_s at sample-2, sample-1 and the sample cycle itself
    assign vote   = {rx_hist, rx_s};
    assign rx_bit = (vote[2] & vote[1]) | (vote[2] & vote[0]) | (vote[1] & vote[0]);
`else
    assign rx_bit = rx_s;
`endif

    // Output contract: o_dv and o_frame_err are single-cycle strobes with no
    // backpressure; o_data is valid while o_dv is high and holds until the next good frame.
    always_ff @(posedge clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        sample  = 1'b0;
        dv_n    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: if (!rx_s) state_n = START;
            START: begin
                sample = (cnt == HALF_LAST);
                if (sample) state_n = rx_bit ? IDLE : DATA;
            end
            DATA: begin
                sample = (cnt == BIT_LAST);
                if (sample && bit_cnt == LAST_BIT) state_n = STOP;
            end
            STOP: begin
                sample = (cnt == BIT_LAST);
                if (sample) begin
                    if (rx_bit) begin
                        dv_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            // A held-low (break) line must not be mistaken for a new start bit
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_s        <= rx_meta;
            o_dv        <= dv_n;
            o_frame_err <= ferr_n;
            if (state == IDLE || state == WAIT_HIGH || sample) cnt <= '0;
            else                                               cnt <= cnt + CW'(1);
            if (state == START) bit_cnt <= '0;
            if (state == DATA && sample) begin
                bit_cnt <= bit_cnt + BW'(1);
                if (LITTLE_ENDIAN != 0) shift <= {rx_bit, shift[WIDTH-1:1]};
                else                    shift <= {shift[WIDTH-2:0], rx_bit};
            end
            if (dv_n) o_data <= shift;
        end
    end

    assign o_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
